lattice_scan_sequencer: RTL and testbench
=========================================

Name: lattice_scan_sequencer

Overview:
Generates the raster sweep of lattice cell coordinates for one simulation timestep. It drives the 9-lane hor/vert inputs of the neighbour-address stage, with the same coordinate on every lane, and produces a matching writeback coordinate stream delayed by the fixed read/collide pipeline depth. It owns the per-timestep start/done handshake, the ping-pong bank select and the timestep counter.

Parameters:
HPIXELS, 205, lattice width in cells
VPIXELS, 154, lattice height in cells
WB_LATENCY, 8, cycles from coordinate issue to writeback coordinate valid; must be at least 1
STEP_WIDTH, 16, width of timestep counter

Ports:
clk_in  input  1  system clock; all logic is rising-edge
rst_in  input  1  synchronous active-high reset
start_in  input  1  single-cycle request to sweep one timestep; honoured only in IDLE
ready_in  input  1  downstream can accept a coordinate this cycle
hor_out  output  9x$clog2(HPIXELS)  current column, replicated on all 9 lanes
vert_out  output  9x$clog2(VPIXELS)  current row, replicated on all 9 lanes
valid_out  output  1  hor_out/vert_out hold a coordinate
wb_hor_out  output  $clog2(HPIXELS)  writeback column
wb_vert_out  output  $clog2(VPIXELS)  writeback row
wb_valid_out  output  1  writeback coordinate valid
bank_out  output  1  read bank for the current sweep; write bank is ~bank_out
busy_out  output  1  high when state is not IDLE
done_out  output  1  one-cycle pulse at end of sweep
step_count_out  output  STEP_WIDTH  completed timesteps, wraps modulo 2^STEP_WIDTH

Behaviour:
- Reset: state IDLE. All counters, delay line, bank_out, step_count_out, valid_out, wb_valid_out, done_out, busy_out and all coordinates are 0. Reset in any state, mid-sweep included, aborts immediately; in-flight writeback entries are discarded and no done_out pulse is produced.
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE: when start_in=1, go to SCAN next cycle with hor=vert=0. Otherwise hold.
- SCAN: valid_out=1 combinationally from state. A transfer ("fire") occurs when valid_out and ready_in are both 1. On fire:
  - hor increments.
  - At HPIXELS-1, hor wraps to 0 and vert increments.
  - Without fire, the coordinate holds; stalls are unbounded.
- SCAN exit: firing on (HPIXELS-1, VPIXELS-1) moves to DRAIN. valid_out is 0 from the next cycle. Exactly HPIXELS*VPIXELS fires occur per sweep, in raster order with hor fastest.
- Writeback delay line: a WB_LATENCY-deep shift register of {fire, hor, vert}. It advances every cycle regardless of ready_in, so stalls appear as bubbles.
  - wb_valid_out at cycle t+WB_LATENCY equals fire at cycle t.
  - wb_hor_out/wb_vert_out carry the coordinate fired at cycle t.
  - Coordinate fields are don't-care when wb_valid_out=0, but must reset to 0.
- DRAIN: lasts exactly WB_LATENCY cycles, counted by an internal down-counter loaded on SCAN exit. If the last fire is at cycle t, DRAIN occupies t+1..t+WB_LATENCY, and the last wb_valid_out occurs at t+WB_LATENCY. The next state is DONE.
- DONE: lasts one cycle.
  - done_out=1 during DONE.
  - On that cycle's edge, bank_out toggles and step_count_out increments.
  - Returns to IDLE.
- start_in in SCAN/DRAIN/DONE is ignored, not queued. start_in on the IDLE cycle right after DONE is accepted normally.
- busy_out = (state != IDLE). done_out and busy_out are both 1 in DONE.
- Coordinate outputs are registered; lane replication is pure wiring.
- Coordinate widths follow $clog2 of the corresponding dimension, consistent with the neighbour-address stage.

Test Plan:
1. HPIXELS=4, VPIXELS=3, WB_LATENCY=5, ready_in=1, start pulse at cycle 0:
   - 12 fires on cycles 1..12 in order (0,0),(1,0),(2,0),(3,0),(0,1)…(3,2).
   - wb_valid_out high on cycles 6..17 with the same sequence.
   - done_out at cycle 18; bank_out=1 and step_count_out=1 from cycle 19.
2. Same config, ready_in low on cycles 3–6:
   - Coordinate (2,0) is held through the stall.
   - wb stream shows a 4-cycle bubble.
   - Total 12 writebacks; done_out at cycle 22.
3. start_in pulsed again at cycles 5 and 18: both ignored, single sweep. A start at cycle 19 starts a second sweep; after it, bank_out=0 and step_count_out=2.
4. rst_in asserted at cycle 8 mid-SCAN:
   - Next cycle, all outputs are 0 and state is IDLE.
   - No further wb_valid_out and no done_out.
   - A fresh start completes a full 12-cell sweep with bank_out=0 at its beginning.
5. WB_LATENCY=1: the last fire at cycle t gives wb_valid_out at t+1, DRAIN for one cycle, and done_out at t+2.
6. Default 205x154: exactly 31570 fires and 31570 writebacks. Final coordinate (204,153), then wrap back to (0,0) on the next sweep.

Source files
------------

// File: rtl/lattice_scan_sequencer_if.sv
// Coordinate/handshake bundle between the scan sequencer and its neighbour-address
// and writeback consumers. Coordinates are replicated on 9 lanes, one per neighbour.
interface lattice_scan_sequencer_if #(
    parameter int unsigned HPIXELS    = 205,
    parameter int unsigned VPIXELS    = 154,
    parameter int unsigned STEP_WIDTH = 16
);
    localparam int unsigned HW = $clog2(HPIXELS);
    localparam int unsigned VW = $clog2(VPIXELS);

    logic                    start_in;
    logic                    ready_in;
    logic [8:0][HW-1:0]      hor_out;
    logic [8:0][VW-1:0]      vert_out;
    logic                    valid_out;
    logic [HW-1:0]           wb_hor_out;
    logic [VW-1:0]           wb_vert_out;
    logic                    wb_valid_out;
    logic                    bank_out;
    logic                    busy_out;
    logic                    done_out;
    logic [STEP_WIDTH-1:0]   step_count_out;

    // Controller side: issues start and ready, consumes the coordinate streams.
    modport master (
        output start_in, ready_in,
        input  hor_out, vert_out, valid_out, wb_hor_out, wb_vert_out, wb_valid_out,
        input  bank_out, busy_out, done_out, step_count_out
    );

    // Sequencer side.
    modport slave (
        input  start_in, ready_in,
        output hor_out, vert_out, valid_out, wb_hor_out, wb_vert_out, wb_valid_out,
        output bank_out, busy_out, done_out, step_count_out
    );
endinterface

// File: rtl/lattice_scan_sequencer.sv
// Raster sweep generator for one lattice timestep: issues every cell coordinate once
// (hor fastest), mirrors accepted coordinates onto a fixed-latency writeback stream,
// then flips the ping-pong bank and bumps the timestep counter.
module lattice_scan_sequencer #(
    parameter int unsigned HPIXELS    = 205,
    parameter int unsigned VPIXELS    = 154,
    parameter int unsigned WB_LATENCY = 8,
    parameter int unsigned STEP_WIDTH = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    lattice_scan_sequencer_if.slave bus
);
    localparam int unsigned HW = $clog2(HPIXELS);
    localparam int unsigned VW = $clog2(VPIXELS);
    localparam int unsigned DW = (WB_LATENCY > 1) ? $clog2(WB_LATENCY) : 1;

    localparam logic [HW-1:0] HMAX  = HW'(HPIXELS - 1);
    localparam logic [VW-1:0] VMAX  = VW'(VPIXELS - 1);
    localparam logic [DW-1:0] DLOAD = DW'(WB_LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [HW-1:0]         hor_q, hor_d;
    logic [VW-1:0]         vert_q, vert_d;
    logic [DW-1:0]         drain_q, drain_d;
    logic                  bank_q, bank_d;
    logic [STEP_WIDTH-1:0] step_q, step_d;

    logic                  valid;
    logic                  fire;

    // Writeback delay line; index 0 is the newest entry.
    logic                  wb_fire_q [WB_LATENCY];
    logic [HW-1:0]         wb_hor_q  [WB_LATENCY];
    logic [VW-1:0]         wb_vert_q [WB_LATENCY];

    assign valid = (state_q == StScan);
    assign fire  = valid & bus.ready_in;

    // Next-state logic: raster advance on each accepted coordinate, drain countdown.
    always_comb begin
        state_d = state_q;
        hor_d   = hor_q;
        vert_d  = vert_q;
        drain_d = drain_q;
        bank_d  = bank_q;
        step_d  = step_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start_in) begin
                    state_d = StScan;
                    hor_d   = '0;
                    vert_d  = '0;
                end
            end
            StScan: begin
                if (fire) begin
                    if (hor_q == HMAX) begin
                        hor_d = '0;
                        if (vert_q == VMAX) begin
                            vert_d  = '0;
                            state_d = StDrain;
                            drain_d = DLOAD;
                        end else begin
                            vert_d = vert_q + 1'b1;
                        end
                    end else begin
                        hor_d = hor_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                // Wait until the last accepted coordinate has left the delay line.
                if (drain_q == '0) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                bank_d  = ~bank_q;
                step_d  = step_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, coordinate, bank and timestep registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            hor_q   <= '0;
            vert_q  <= '0;
            drain_q <= '0;
            bank_q  <= 1'b0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            hor_q   <= hor_d;
            vert_q  <= vert_d;
            drain_q <= drain_d;
            bank_q  <= bank_d;
            step_q  <= step_d;
        end
    end

    // Delay line shifts every cycle so stalls surface as writeback bubbles.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < int'(WB_LATENCY); i++) begin
                wb_fire_q[i] <= 1'b0;
                wb_hor_q[i]  <= '0;
                wb_vert_q[i] <= '0;
            end
        end else begin
            for (int i = int'(WB_LATENCY) - 1; i > 0; i--) begin
                wb_fire_q[i] <= wb_fire_q[i-1];
                wb_hor_q[i]  <= wb_hor_q[i-1];
                wb_vert_q[i] <= wb_vert_q[i-1];
            end
            wb_fire_q[0] <= fire;
            wb_hor_q[0]  <= hor_q;
            wb_vert_q[0] <= vert_q;
        end
    end

    assign bus.hor_out        = {9{hor_q}};
    assign bus.vert_out       = {9{vert_q}};
    assign bus.valid_out      = valid;
    assign bus.wb_valid_out   = wb_fire_q[WB_LATENCY-1];
    assign bus.wb_hor_out     = wb_hor_q[WB_LATENCY-1];
    assign bus.wb_vert_out    = wb_vert_q[WB_LATENCY-1];
    assign bus.bank_out       = bank_q;
    assign bus.busy_out       = (state_q != StIdle);
    assign bus.done_out       = (state_q == StDone);
    assign bus.step_count_out = step_q;
endmodule

// File: tb/tb_lattice_scan_sequencer.sv
// Bench for the scan sequencer: three instances (4x3 latency 5, 4x3 latency 1, 205x154
// latency 8) run side by side against a cycle-level model built from the sweep rules.
module tb_lattice_scan_sequencer;
    logic       clk = 1'b0;
    logic [2:0] rst_v   = 3'b111;
    logic [2:0] start_v = 3'b000;
    logic [2:0] ready_v = 3'b111;

    always #5 clk = ~clk;

    lattice_scan_sequencer_if #(.HPIXELS(4), .VPIXELS(3), .STEP_WIDTH(16)) bus0 ();
    lattice_scan_sequencer_if #(.HPIXELS(4), .VPIXELS(3), .STEP_WIDTH(16)) bus1 ();
    lattice_scan_sequencer_if #(.HPIXELS(205), .VPIXELS(154), .STEP_WIDTH(16)) bus2 ();

    assign bus0.start_in = start_v[0];
    assign bus0.ready_in = ready_v[0];
    assign bus1.start_in = start_v[1];
    assign bus1.ready_in = ready_v[1];
    assign bus2.start_in = start_v[2];
    assign bus2.ready_in = ready_v[2];

    lattice_scan_sequencer #(.HPIXELS(4), .VPIXELS(3), .WB_LATENCY(5), .STEP_WIDTH(16)) dut0 (
        .clk_in (clk),
        .rst_in (rst_v[0]),
        .bus    (bus0)
    );
    lattice_scan_sequencer #(.HPIXELS(4), .VPIXELS(3), .WB_LATENCY(1), .STEP_WIDTH(16)) dut1 (
        .clk_in (clk),
        .rst_in (rst_v[1]),
        .bus    (bus1)
    );
    lattice_scan_sequencer #(.HPIXELS(205), .VPIXELS(154), .WB_LATENCY(8), .STEP_WIDTH(16))
    dut2 (
        .clk_in (clk),
        .rst_in (rst_v[2]),
        .bus    (bus2)
    );

    int cfg_h [3] = '{4, 4, 205};
    int cfg_v [3] = '{3, 3, 154};
    int cfg_l [3] = '{5, 1, 8};

    // Observed outputs, flattened per instance.
    logic [31:0] o_hor [3], o_vert [3], o_wbh [3], o_wbv [3], o_step [3];
    logic        o_valid [3], o_wbvalid [3], o_bank [3], o_busy [3], o_done [3];
    logic        o_lane_ok [3];

    always_comb begin
        for (int d = 0; d < 3; d++) o_lane_ok[d] = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (bus0.hor_out[k] !== bus0.hor_out[0] || bus0.vert_out[k] !== bus0.vert_out[0])
                o_lane_ok[0] = 1'b0;
            if (bus1.hor_out[k] !== bus1.hor_out[0] || bus1.vert_out[k] !== bus1.vert_out[0])
                o_lane_ok[1] = 1'b0;
            if (bus2.hor_out[k] !== bus2.hor_out[0] || bus2.vert_out[k] !== bus2.vert_out[0])
                o_lane_ok[2] = 1'b0;
        end
        o_hor[0] = 32'(bus0.hor_out[0]);  o_vert[0] = 32'(bus0.vert_out[0]);
        o_hor[1] = 32'(bus1.hor_out[0]);  o_vert[1] = 32'(bus1.vert_out[0]);
        o_hor[2] = 32'(bus2.hor_out[0]);  o_vert[2] = 32'(bus2.vert_out[0]);
        o_wbh[0] = 32'(bus0.wb_hor_out);  o_wbv[0] = 32'(bus0.wb_vert_out);
        o_wbh[1] = 32'(bus1.wb_hor_out);  o_wbv[1] = 32'(bus1.wb_vert_out);
        o_wbh[2] = 32'(bus2.wb_hor_out);  o_wbv[2] = 32'(bus2.wb_vert_out);
        o_step[0] = 32'(bus0.step_count_out);
        o_step[1] = 32'(bus1.step_count_out);
        o_step[2] = 32'(bus2.step_count_out);
        o_valid[0] = bus0.valid_out;  o_wbvalid[0] = bus0.wb_valid_out;
        o_valid[1] = bus1.valid_out;  o_wbvalid[1] = bus1.wb_valid_out;
        o_valid[2] = bus2.valid_out;  o_wbvalid[2] = bus2.wb_valid_out;
        o_bank[0] = bus0.bank_out;  o_busy[0] = bus0.busy_out;  o_done[0] = bus0.done_out;
        o_bank[1] = bus1.bank_out;  o_busy[1] = bus1.busy_out;  o_done[1] = bus1.done_out;
        o_bank[2] = bus2.bank_out;  o_busy[2] = bus2.busy_out;  o_done[2] = bus2.done_out;
    end

    // Reference model: sweep progress as a cell index, plus a by-cycle history of what
    // was accepted so the writeback stream is "whatever fired L cycles ago".
    int  cyc = 0;
    bit  m_scan [3], m_busy [3], m_bank [3], m_zero [3];
    int  m_idx [3], m_step [3], m_done [3];
    bit  h_fire [3][64];
    int  h_h [3][64], h_v [3][64];

    int  vectors = 0;
    int  miscompares = 0;
    int  wb2_cnt = 0, fire2_cnt = 0;

    task automatic chk(input int d, input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL dut%0d %s at cycle %0d: observed %0d expected %0d",
                   d, tag, cyc, obs, exp);
        end
    endtask

    task automatic check_dut(input int d);
        int  c;
        bit  ewv;
        int  eh, ev;
        c   = cyc - cfg_l[d];
        ewv = (c >= 0) ? h_fire[d][c % 64] : 1'b0;
        eh  = (c >= 0) ? h_h[d][c % 64] : 0;
        ev  = (c >= 0) ? h_v[d][c % 64] : 0;
        chk(d, "valid", 32'(o_valid[d]), 32'(m_scan[d]));
        chk(d, "busy", 32'(o_busy[d]), 32'(m_busy[d]));
        chk(d, "done", 32'(o_done[d]), 32'(m_busy[d] && !m_scan[d] && cyc == m_done[d]));
        chk(d, "bank", 32'(o_bank[d]), 32'(m_bank[d]));
        chk(d, "step", o_step[d], 32'(m_step[d]));
        chk(d, "wb_valid", 32'(o_wbvalid[d]), 32'(ewv));
        chk(d, "lanes_equal", 32'(o_lane_ok[d]), 32'd1);
        if (m_scan[d]) begin
            chk(d, "hor", o_hor[d], 32'(m_idx[d] % cfg_h[d]));
            chk(d, "vert", o_vert[d], 32'(m_idx[d] / cfg_h[d]));
        end
        if (ewv) begin
            chk(d, "wb_hor", o_wbh[d], 32'(eh));
            chk(d, "wb_vert", o_wbv[d], 32'(ev));
        end
        if (m_zero[d]) begin
            chk(d, "hor_after_reset", o_hor[d], 32'd0);
            chk(d, "vert_after_reset", o_vert[d], 32'd0);
            chk(d, "wb_hor_after_reset", o_wbh[d], 32'd0);
            chk(d, "wb_vert_after_reset", o_wbv[d], 32'd0);
        end
    endtask

    task automatic model_edge(input int d);
        bit fire;
        int slot;
        fire = m_scan[d] && ready_v[d];
        slot = cyc % 64;
        h_fire[d][slot] = fire;
        h_h[d][slot]    = m_idx[d] % cfg_h[d];
        h_v[d][slot]    = m_idx[d] / cfg_h[d];
        m_zero[d] = 1'b0;
        if (rst_v[d]) begin
            m_scan[d] = 1'b0;
            m_busy[d] = 1'b0;
            m_idx[d]  = 0;
            m_bank[d] = 1'b0;
            m_step[d] = 0;
            m_done[d] = -1;
            m_zero[d] = 1'b1;
            for (int i = 0; i < 64; i++) begin
                h_fire[d][i] = 1'b0;
                h_h[d][i]    = 0;
                h_v[d][i]    = 0;
            end
        end else if (m_busy[d] && !m_scan[d]) begin
            if (cyc == m_done[d]) begin
                m_busy[d] = 1'b0;
                m_bank[d] = ~m_bank[d];
                m_step[d] = (m_step[d] + 1) % 65536;
            end
        end else if (m_scan[d]) begin
            if (fire) begin
                m_idx[d]++;
                if (m_idx[d] == cfg_h[d] * cfg_v[d]) begin
                    m_scan[d] = 1'b0;
                    m_done[d] = cyc + cfg_l[d] + 1;
                end
            end
        end else if (start_v[d]) begin
            m_busy[d] = 1'b1;
            m_scan[d] = 1'b1;
            m_idx[d]  = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < 3; d++) check_dut(d);
        if (o_wbvalid[2] === 1'b1) wb2_cnt++;
        if (o_valid[2] === 1'b1 && ready_v[2]) fire2_cnt++;
        for (int d = 0; d < 3; d++) model_edge(d);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_idle(input int d, input int max_cycles);
        int n;
        n = 0;
        while (m_busy[d] && n < max_cycles) begin
            tick();
            n++;
        end
        if (m_busy[d]) begin
            vectors++;
            miscompares++;
            $error("FAIL dut%0d sweep_timeout after %0d cycles", d, max_cycles);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            m_scan[d] = 1'b0; m_busy[d] = 1'b0; m_bank[d] = 1'b0; m_zero[d] = 1'b1;
            m_idx[d] = 0; m_step[d] = 0; m_done[d] = -1;
        end

        // Reset all instances.
        tick();
        tick();
        rst_v = 3'b000;
        tick();

        // Full-throughput sweeps on both small instances (latency 5 and latency 1).
        start_v = 3'b011;
        tick();
        start_v = 3'b000;
        run_idle(0, 200);
        run_idle(1, 200);
        tick();

        // Four-cycle stall holding coordinate (2,0).
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        tick();
        tick();
        ready_v[0] = 1'b0;
        repeat (4) tick();
        ready_v[0] = 1'b1;
        run_idle(0, 200);
        tick();

        // Starts during SCAN and DONE are dropped; start on the following IDLE cycle runs.
        start_v[0] = 1'b1;
        tick();
        for (int r = 1; r <= 18; r++) begin
            start_v[0] = (r == 5 || r == 18);
            tick();
        end
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        run_idle(0, 200);
        tick();

        // Reset in the middle of a sweep, then a fresh sweep.
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (7) tick();
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        repeat (10) tick();
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        run_idle(0, 200);

        // Random traffic on the small instances: backpressure, stray starts, rare resets.
        for (int i = 0; i < 900; i++) begin
            for (int d = 0; d < 2; d++) begin
                ready_v[d] = ($urandom_range(0, 3) != 0);
                start_v[d] = ($urandom_range(0, 7) == 0);
                rst_v[d]   = ($urandom_range(0, 249) == 0);
            end
            tick();
        end
        rst_v   = 3'b000;
        start_v = 3'b000;
        ready_v = 3'b111;
        run_idle(0, 200);
        run_idle(1, 200);

        // Full-size lattice: one complete sweep, then the start of the next.
        start_v[2] = 1'b1;
        tick();
        start_v[2] = 1'b0;
        wb2_cnt   = 0;
        fire2_cnt = 0;
        run_idle(2, 40000);
        chk(2, "fire_total", 32'(fire2_cnt), 32'd31570);
        chk(2, "wb_total", 32'(wb2_cnt), 32'd31570);
        start_v[2] = 1'b1;
        tick();
        start_v[2] = 1'b0;
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
